aes_enc_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative AES encryption core (`Encrypt_Iterative`) between `NUM_REQ` requesters. It accepts 128-bit plaintext blocks over per-requester valid/ready channels and drives the core's level-held `start`. It captures the ciphertext on `done` and returns it on a single tagged response channel. It sits between the block-level clients and the core instance; the key is shared and supplied by the configuration register.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_enc_arbiter_if.sv | 28 ++
 rtl/aes_rr_pick.sv | 28 ++
 rtl/aes_enc_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and arbiter FSM state encoding.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W    = 128;

    localparam int unsigned AES_KEY128_W   = 128;
    localparam int unsigned AES_KEY192_W   = 192;
    localparam int unsigned AES_KEY256_W   = 256;

    localparam int unsigned AES_ROUNDS_128 = 10;
    localparam int unsigned AES_ROUNDS_192 = 12;
    localparam int unsigned AES_ROUNDS_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/aes_enc_arbiter_if.sv
// Requester/response bus between AES clients and the arbiter.
interface aes_enc_arbiter_if
    import aes_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*AES_BLOCK_W-1:0] req_data;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [AES_BLOCK_W-1:0]         resp_data;
    logic [ID_W-1:0]                resp_id;
    logic                           resp_err;

    // Client side: drives blocks, consumes responses.
    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );
endinterface

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first valid requester above `last`, wrapping.
module aes_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [IDX_W-1:0] cand_c;

    // Scan last+1 .. last+NUM_REQ modulo NUM_REQ; keep the first hit.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        cand_c  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_c = IDX_W'((32'(last) + k) % NUM_REQ);
            if (grant_c == '0 && req_valid[cand_c]) begin
                grant_c[cand_c] = 1'b1;
                idx_c           = cand_c;
            end
        end
    end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative AES encrypt core.
// Optional run watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_enc_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_W           = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_enc_arbiter_if.slave       bus,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_in,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_out,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    // Reject unsupported parameterisations at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("aes_enc_arbiter: NUM_REQ must be 2..8");
    end
    if (ID_W < IDX_W) begin : g_bad_id_w
        $error("aes_enc_arbiter: ID_W too narrow for NUM_REQ");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_enc_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [AES_BLOCK_W-1:0] core_in_q, core_in_d;
    logic [AES_BLOCK_W-1:0] resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0]     grant_c;
    logic [IDX_W-1:0]       pick_idx_c;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    aes_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (bus.req_valid),
        .last      (last_q),
        .grant_c   (grant_c),
        .idx_c     (pick_idx_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            id_q        <= '0;
            core_in_q   <= '0;
            resp_data_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            core_in_q   <= core_in_d;
            resp_data_q <= resp_data_d;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state: accept in IDLE, wait for done (or watchdog) in RUN, handshake in RESP.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        core_in_d   = core_in_q;
        resp_data_d = resp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    state_d   = ST_RUN;
                    last_d    = pick_idx_c;
                    id_d      = ID_W'(pick_idx_c);
                    core_in_d = bus.req_data[AES_BLOCK_W*32'(pick_idx_c) +: AES_BLOCK_W];
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            ST_RUN: begin
`ifdef AES_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (core_done) begin
                    state_d     = ST_RESP;
                    resp_data_d = core_out;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = ST_RESP;
                    resp_data_d = '0;
                    err_d       = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is the live grant while idle.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        core_start     = 1'b0;
        busy           = (state_q != ST_IDLE);
        core_in        = core_in_q;
        bus.resp_data  = resp_data_q;
        bus.resp_id    = id_q;
`ifdef AES_ARB_TIMEOUT_EN
        bus.resp_err   = err_q;
`else
        bus.resp_err   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: bus.req_ready  = grant_c;
            ST_RUN:  core_start     = 1'b1;
            ST_RESP: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
